dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder for the pipeline's MEM stage: serves load/store requests on the
//   ALUResultM/WriteDataM/MemWriteM interface and returns ReadDataM.
// - Models a LATENCY-cycle memory: holds MemStallM to the hazard unit until the access completes.
// - Word-addressed internal array; a misaligned word access raises AlignFaultM.
// PARAMETERS
// - DEPTH    1024  number of 32-bit words; power of two; AW = $clog2(DEPTH)
// - LATENCY  2     cycles from request acceptance to completion; legal range 1..15
// PORTS
// - clk         in   1   clock, rising edge
// - reset       in   1   synchronous, active-low (reset==0 resets on the rising edge)
// - MemReqM     in   1   MEM-stage access request (load or store)
// - MemWriteM   in   1   1 = store, 0 = load; qualified by MemReqM
// - ByteM       in   1   byte access (LDRB/STRB); used only with DMEM_BYTE_EN
// - ALUResultM  in   32  byte address
// - WriteDataM  in   32  store data
// - ReadDataM   out  32  load data; valid only while MemDoneM=1, 0 otherwise
// - MemStallM   out  1   combinational stall to the hazard unit
// - MemDoneM    out  1   one-cycle completion pulse
// - AlignFaultM out  1   misaligned word access; valid only while MemDoneM=1
// BEHAVIOUR
// - FSM states: IDLE, WAIT, DONE. 4-bit down-counter cnt.
// - IDLE: MemReqM=1 accepts in cycle T: latch addr/wdata/write/byte, cnt<=LATENCY-1;
//   next state DONE if LATENCY==1, else WAIT. MemReqM=0: remain in IDLE.
// - WAIT: cnt<=cnt-1; go to DONE when cnt==1. WAIT lasts exactly LATENCY-1 cycles.
// - DONE (cycle T+LATENCY): MemDoneM=1; the store commits to the array on the closing edge;
//   the next state is always IDLE. Requests are not re-accepted in DONE.
// - MemStallM = (IDLE & MemReqM) | WAIT. It is high in cycles T..T+LATENCY-1 and low in DONE.
//   The pipeline advances at the end of DONE.
// - The requester holds its inputs stable while MemStallM=1; only the latched copies are used.
// - Index = addr[AW+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH words.
// - Load: ReadDataM = mem[index] in DONE. Store: ReadDataM = 0.
// - A store followed immediately by a load to the same word returns the new data, because
//   the commit happens before the next acceptance.
// - Misaligned (addr[1:0]!=0, word access): AlignFaultM=1 in DONE. The store is suppressed
//   and ReadDataM = 0.
// - Reset: state=IDLE, cnt=0, and all outputs 0 (MemStallM=0 even if MemReqM=1 during reset).
//   The array is not cleared.
// - Reset mid-access (WAIT or DONE) aborts the access. The pending store is dropped and no
//   MemDoneM pulse occurs.
// CONFIGURATION
// - DMEM_BYTE_EN defined: ByteM=1 selects byte lane addr[1:0].
//   - STRB writes WriteDataM[7:0] into that lane only; the other lanes are unchanged.
//   - LDRB returns the zero-extended byte.
//   - Byte accesses never raise AlignFaultM.
// - DMEM_BYTE_EN undefined: ByteM is ignored; all accesses are word accesses with the
//   alignment check.
// TESTING
// - LATENCY=2, store 0xDEADBEEF @0x10, then load @0x10 -> MemStallM high for 2 cycles each;
//   MemDoneM at T+2; load returns 0xDEADBEEF.
// - LATENCY=1, back-to-back loads @0x0,@0x4 -> MemStallM 1,0,1,0; MemDoneM alternates;
//   each result is correct.
// - Word load @0x12 -> AlignFaultM=1 and ReadDataM=0 in DONE. Word store @0x13 -> the array
//   is unchanged (read back the old word).
// - DEPTH=1024, store 0x11 @0x1000, then load @0x0 -> returns 0x11 (wrap-around).
// - Store accepted, reset=0 asserted in WAIT -> no MemDoneM; the target word keeps its old
//   value; all outputs 0 after reset.
// - DMEM_BYTE_EN: word 0xAABBCCDD @0x20, STRB 0x55 @0x21, then word load -> 0xAABB55DD;
//   LDRB @0x23 -> 0x000000AA.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store request and response signals
interface dmem_responder_if;
    logic        MemReqM;
    logic        MemWriteM;
    logic        ByteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic        MemDoneM;
    logic        AlignFaultM;
    modport master (
        output MemReqM, MemWriteM, ByteM, ALUResultM, WriteDataM,
        input  ReadDataM, MemStallM, MemDoneM, AlignFaultM
    );
    modport slave (
        input  MemReqM, MemWriteM, ByteM, ALUResultM, WriteDataM,
        output ReadDataM, MemStallM, MemDoneM, AlignFaultM
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: LATENCY-cycle word memory for the MEM stage; define DMEM_BYTE_EN for byte lanes
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t        state;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          write_q;
    logic [31:0]   mem [DEPTH];
    logic          accept, go_done, commit, a_write, a_byte, a_fault;
    logic [AW+1:0] a_addr;
    logic [31:0]   a_word, a_rd;
    logic          unused_bits;
    assign accept  = state == IDLE && bus.MemReqM;
    assign go_done = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    // With LATENCY==1 the result is formed in the accept cycle, before the latches hold the request.
    assign a_addr  = accept ? bus.ALUResultM[AW+1:0] : addr_q;
    assign a_write = accept ? bus.MemWriteM : write_q;
`ifdef DMEM_BYTE_EN
    logic byte_q;
    assign a_byte      = accept ? bus.ByteM : byte_q;
    assign unused_bits = ^bus.ALUResultM[31:AW+2];
`else
    assign a_byte      = 1'b0;
    assign unused_bits = ^{bus.ALUResultM[31:AW+2], bus.ByteM};
`endif
    assign a_fault = !a_byte && a_addr[1:0] != 2'b00;
    assign a_word  = mem[a_addr[AW+1:2]];
    assign a_rd    = a_byte ? {24'b0, 8'(a_word >> {a_addr[1:0], 3'b000})} : a_word;
    assign commit  = reset && state == DONE && write_q && !bus.AlignFaultM;
    assign bus.MemStallM = reset && (accept || state == WAIT);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.ReadDataM   <= '0;
            bus.MemDoneM    <= 1'b0;
            bus.AlignFaultM <= 1'b0;
        end else begin
            bus.MemDoneM    <= go_done;
            bus.AlignFaultM <= go_done && a_fault;
            bus.ReadDataM   <= go_done && !a_write && !a_fault ? a_rd : '0;
            case (state)
                IDLE: if (bus.MemReqM) begin
                    addr_q  <= bus.ALUResultM[AW+1:0];
                    wdata_q <= bus.WriteDataM;
                    write_q <= bus.MemWriteM;
`ifdef DMEM_BYTE_EN
                    byte_q  <= bus.ByteM;
`endif
                    cnt     <= 4'(LATENCY - 1);
                    state   <= LATENCY == 1 ? DONE : WAIT;
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= cnt == 4'd1 ? DONE : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
`ifdef DMEM_BYTE_EN
        if (commit && byte_q)
            mem[addr_q[AW+1:2]][{addr_q[1:0], 3'b000} +: 8] <= wdata_q[7:0];
        else if (commit)
            mem[addr_q[AW+1:2]] <= wdata_q;
`else
        if (commit)
            mem[addr_q[AW+1:2]] <= wdata_q;
`endif
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a LATENCY=2 and a LATENCY=1 responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, wr = 1'b0, byt = 1'b0, sel = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        stall, done, fault;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    dmem_responder_if b1 ();
    dmem_responder_if b2 ();

    assign b1.MemReqM    = req && sel;
    assign b2.MemReqM    = req && !sel;
    assign b1.MemWriteM  = wr;
    assign b2.MemWriteM  = wr;
    assign b1.ByteM      = byt;
    assign b2.ByteM      = byt;
    assign b1.ALUResultM = addr;
    assign b2.ALUResultM = addr;
    assign b1.WriteDataM = wdata;
    assign b2.WriteDataM = wdata;
    assign rdata = sel ? b1.ReadDataM   : b2.ReadDataM;
    assign stall = sel ? b1.MemStallM   : b2.MemStallM;
    assign done  = sel ? b1.MemDoneM    : b2.MemDoneM;
    assign fault = sel ? b1.AlignFaultM : b2.AlignFaultM;

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (.clk(clk), .reset(rst_n), .bus(b1));
    dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut2 (.clk(clk), .reset(rst_n), .bus(b2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic s, input logic [31:0] a, input logic [31:0] w,
                          input logic wr_i, input logic b_i,
                          output logic [31:0] rd, output logic f, output int stalls);
        logic seen;
        seen = 1'b0;
        stalls = 0;
        rd = '0;
        f = 1'b0;
        @(negedge clk);
        sel = s; addr = a; wdata = w; wr = wr_i; byt = b_i; req = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (done) begin
                seen = 1'b1;
                rd = rdata;
                f = fault;
                check("stall_in_done", {31'b0, stall}, 32'd0);
                req = 1'b0;
            end else begin
                stalls += int'(stall);
                @(negedge clk);
            end
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        req = 1'b0;
        byt = 1'b0;
    endtask

    logic [31:0] rd;
    logic        f;
    int          st;

    initial begin
        sel = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h10;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall2", {31'b0, b2.MemStallM}, 32'd0);
        check("rst_stall1", {31'b0, b1.MemStallM}, 32'd0);
        check("rst_done", {31'b0, b2.MemDoneM}, 32'd0);
        check("rst_fault", {31'b0, b2.AlignFaultM}, 32'd0);
        check("rst_rdata", b2.ReadDataM, 32'd0);
        req = 1'b0;
        rst_n = 1'b1;

        access(1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, rd, f, st);
        check("st10_stalls", st, 2);
        check("st10_rdata", rd, 32'd0);
        check("st10_fault", {31'b0, f}, 32'd0);
        access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, rd, f, st);
        check("ld10_stalls", st, 2);
        check("ld10_rdata", rd, 32'hDEADBEEF);
        check("ld10_fault", {31'b0, f}, 32'd0);
        @(negedge clk);
        #1;
        check("done_one_cycle", {31'b0, done}, 32'd0);

        access(1'b0, 32'h12, 32'h0, 1'b0, 1'b0, rd, f, st);
        check("ld12_fault", {31'b0, f}, 32'd1);
        check("ld12_rdata", rd, 32'd0);
        access(1'b0, 32'h14, 32'h12345678, 1'b1, 1'b0, rd, f, st);
        access(1'b0, 32'h17, 32'hCAFEF00D, 1'b1, 1'b0, rd, f, st);
        check("st17_fault", {31'b0, f}, 32'd1);
        access(1'b0, 32'h14, 32'h0, 1'b0, 1'b0, rd, f, st);
        check("ld14_unchanged", rd, 32'h12345678);

        access(1'b0, 32'h1000, 32'h11, 1'b1, 1'b0, rd, f, st);
        access(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rd, f, st);
        check("wrap_rdata", rd, 32'h11);

        @(negedge clk);
        sel = 1'b0; addr = 32'h10; wdata = 32'h99; wr = 1'b1; req = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0;
        @(negedge clk);
        #1;
        check("abort_done", {31'b0, b2.MemDoneM}, 32'd0);
        check("abort_stall", {31'b0, b2.MemStallM}, 32'd0);
        check("abort_rdata", b2.ReadDataM, 32'd0);
        check("abort_fault", {31'b0, b2.AlignFaultM}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, rd, f, st);
        check("abort_keep", rd, 32'hDEADBEEF);

        access(1'b1, 32'h0, 32'hA0A0A0A0, 1'b1, 1'b0, rd, f, st);
        check("l1_st0_stalls", st, 1);
        access(1'b1, 32'h4, 32'h0B0B0B0B, 1'b1, 1'b0, rd, f, st);
        access(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, rd, f, st);
        check("l1_ld0_stalls", st, 1);
        check("l1_ld0_rdata", rd, 32'hA0A0A0A0);
        access(1'b1, 32'h4, 32'h0, 1'b0, 1'b0, rd, f, st);
        check("l1_ld4_stalls", st, 1);
        check("l1_ld4_rdata", rd, 32'h0B0B0B0B);

`ifdef DMEM_BYTE_EN
        access(1'b0, 32'h20, 32'hAABBCCDD, 1'b1, 1'b0, rd, f, st);
        access(1'b0, 32'h21, 32'h00000055, 1'b1, 1'b1, rd, f, st);
        check("strb_fault", {31'b0, f}, 32'd0);
        access(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, rd, f, st);
        check("strb_word", rd, 32'hAABB55DD);
        access(1'b0, 32'h23, 32'h0, 1'b0, 1'b1, rd, f, st);
        check("ldrb_rdata", rd, 32'h000000AA);
        check("ldrb_fault", {31'b0, f}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
